pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  PC register and instruction-fetch sequencer for the 16-bit WISC core; sits upstream of the
//  branch-target adder. Holds the architectural PC, drives the instruction-memory request
//  handshake, and presents one fetched instruction at a time to decode. It also exports PC+2
//  as the adder base and accepts the adder's target as a redirect.
// PARAMETERS
//  RESET_PC  16'h0000  PC value loaded on reset
//  HALT_OP   4'hF      opcode (instr[15:12]) that stops fetching
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   synchronous reset, active-high
//  imem_req        out  1   fetch request; held until imem_ack
//  imem_addr       out  16  fetch address; stable while imem_req=1
//  imem_ack        in   1   one-cycle pulse: imem_rdata valid this cycle
//  imem_rdata      in   16  fetched instruction word
//  instr           out  16  instruction presented to decode
//  instr_pc        out  16  PC of instr
//  pc_plus2        out  16  instr_pc+2 (base for branch-target adder)
//  instr_valid     out  1   instr/instr_pc/pc_plus2 valid
//  instr_ready     in   1   decode accepts instr when instr_valid&instr_ready
//  redirect        in   1   taken branch/jump: refetch from redirect_target
//  redirect_target in   16  new PC; bit0 forced to 0
//  halted          out  1   HALT fetched and presented; fetch stopped
// BEHAVIOUR
//  States: IDLE, REQ, HOLD, DRAIN, HALT. All outputs registered.
//  - Reset: state=IDLE; pc=RESET_PC; imem_req=0; instr_valid=0; halted=0.
//    instr, instr_pc and pc_plus2 = 0. Reset beats everything, mid-transaction too.
//    A pending ack after reset is ignored.
//  - IDLE: next cycle -> REQ.
//  - REQ: imem_req=1, imem_addr=pc.
//    On imem_ack (no redirect): instr<=rdata, instr_pc<=pc, pc_plus2<=pc+2, instr_valid<=1.
//    If rdata[15:12]==HALT_OP: pc unchanged, -> HALT. Otherwise pc<=pc+2, -> HOLD.
//  - HOLD: imem_req=0, outputs stable. On instr_valid&instr_ready: instr_valid<=0, -> REQ.
//    Effective fetch latency = mem latency + 1 cycle per instruction.
//  - Redirect (highest priority after rst):
//    - pc<=redirect_target&16'hFFFE; instr_valid<=0; halted<=0.
//    - In REQ without ack: keep imem_req/addr until ack, -> DRAIN; ack data is discarded, -> REQ.
//    - In REQ with ack the same cycle: data discarded, -> REQ.
//    - In HOLD, DRAIN, IDLE or HALT: -> REQ (DRAIN stays DRAIN until its ack).
//    - In HOLD with instr_ready the same cycle: instr is NOT considered accepted.
//  - HALT: instr_valid=1, halted=1, imem_req=0; instr_ready ignored. Exit only via redirect or rst.
//  - Arithmetic: 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000, no flag.
//  - imem_ack outside REQ/DRAIN is a protocol error; it is ignored and has no state effect.
// TESTING
//  1 rst, mem ack latency 1, ready=1 -> addrs 0000,0002,0004; instr_valid 1 cycle each,
//    instr_pc matches the address.
//  2 ready=0 for 5 cycles in HOLD -> instr/instr_valid stable; imem_req=0; pc not advanced.
//  3 redirect to 16'h0101 while REQ awaits ack (latency 3) -> addr held until ack, data dropped;
//    next req addr=16'h0100; no instr_valid in between.
//  4 fetch rdata=16'hF000 at pc 0006 -> halted=1, instr_pc=0006, no further req.
//    Then redirect 16'h0040 -> halted=0, req at 0040.
//  5 RESET_PC=16'hFFFE -> first instr_pc=FFFE, pc_plus2=0000, next addr=0000.
//  6 rst asserted mid-REQ with ack the same cycle -> all outputs at reset values next cycle;
//    the ack data never appears on instr.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: architectural PC and instruction-fetch sequencer for the
// 16-bit WISC core. Issues one memory request at a time, presents each
// fetched word to decode, exports PC+2 for the branch-target adder and
// accepts redirects from that adder.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | out of reset; start the first fetch next cycle
//  REQ   | imem_req high at imem_addr, waiting for imem_ack
//  HOLD  | instruction presented to decode, waiting for instr_ready
//  DRAIN | redirected mid-request; wait for the stale ack and drop it
//  HALT  | HALT opcode presented; fetch stopped until redirect or rst
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_target,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] redir_pc;

    // Instructions are halfword aligned, so the target LSB is dropped.
    assign redir_pc = redirect_target & 16'hFFFE;

    // Sequencer state, PC and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
            pc_plus2    <= 16'h0000;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (redirect) begin
            pc          <= redir_pc;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        // Ack lands with the redirect: drop it, refetch now.
                        state     <= S_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= redir_pc;
                    end else begin
                        // Request already on the bus must complete unchanged.
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        state     <= S_REQ;
                        imem_addr <= redir_pc;
                    end
                end
                default: begin
                    state     <= S_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= redir_pc;
                end
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        pc_plus2    <= pc + 16'd2;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        if (imem_rdata[15:12] == HALT_OP) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            pc    <= pc + 16'd2;
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_valid && instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= S_REQ;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc;
                    end
                end
                S_DRAIN: begin
                    // Stale data is discarded; request stays high for the new PC.
                    if (imem_ack) begin
                        state     <= S_REQ;
                        imem_addr <= pc;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl with RESET_PC = 16'hFFFE so the first fetch also
// exercises the 16-bit wrap. A memory responder acks after a programmable
// latency; the stimulus pushes expected fetch addresses and presented
// instructions into queues, and a monitor pops and compares them.
module tb_pc_fetch_ctrl;

    localparam logic [15:0] RST_PC = 16'hFFFE;

    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] pc;
        logic [15:0] pc2;
        logic        hlt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        halted;

    logic        nat_ack;
    logic        inj_ack;
    int          mem_lat;
    int          mode;
    int          to_cnt;
    logic [15:0] to_pc;
    logic        end_chk;

    int          total;
    int          bad;

    logic [15:0] exp_addr[$];
    exp_t        exp_ins[$];

    pc_fetch_ctrl #(.RESET_PC(RST_PC), .HALT_OP(4'hF)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .pc_plus2        (pc_plus2),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ack = nat_ack | inj_ack;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0006) return 16'hF000;
        return 16'h1000 | {4'h0, a[11:0]};
    endfunction

    // Memory responder: acks mem_lat cycles after the request is first seen.
    initial begin
        int cnt;
        cnt = 0;
        nat_ack = 1'b0;
        imem_rdata = 16'hBEEF;
        forever begin
            @(posedge clk);
            #1;
            nat_ack = 1'b0;
            imem_rdata = 16'hBEEF;
            if (imem_req) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    nat_ack = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    initial begin
        logic        prev_valid;
        logic        prev_ready;
        logic        prev_halted;
        int          to_seen;
        logic        end_done;
        logic [15:0] a;
        exp_t        e;
        total = 0;
        bad = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_halted = 1'b0;
        to_seen = 0;
        end_done = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_ack && imem_req) begin
                if (exp_addr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fetch_addr: unexpected fetch of %h", imem_addr);
                end else begin
                    a = exp_addr.pop_front();
                    chk("fetch_addr", imem_addr, a);
                end
            end
            if (instr_valid && !prev_valid) begin
                if (exp_ins.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL instr: unexpected instr %h at pc %h", instr, instr_pc);
                end else begin
                    e = exp_ins.pop_front();
                    chk("instr", instr, e.ins);
                    chk("instr_pc", instr_pc, e.pc);
                    chk("pc_plus2", pc_plus2, e.pc2);
                    chk("halted", {15'd0, halted}, {15'd0, e.hlt});
                end
            end
            if (prev_valid && prev_ready && !prev_halted)
                chk("valid_drop", {15'd0, instr_valid}, 16'd0);
            case (mode)
                1: begin
                    chk("rst_req", {15'd0, imem_req}, 16'd0);
                    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
                    chk("rst_halted", {15'd0, halted}, 16'd0);
                    chk("rst_instr", instr, 16'h0000);
                    chk("rst_instr_pc", instr_pc, 16'h0000);
                    chk("rst_pc_plus2", pc_plus2, 16'h0000);
                end
                2: begin
                    chk("hold_valid", {15'd0, instr_valid}, 16'd1);
                    chk("hold_req", {15'd0, imem_req}, 16'd0);
                    chk("hold_instr", instr, 16'h1004);
                    chk("hold_instr_pc", instr_pc, 16'h0004);
                    chk("hold_pc_plus2", pc_plus2, 16'h0006);
                end
                3: begin
                    chk("halt_req", {15'd0, imem_req}, 16'd0);
                    chk("halt_valid", {15'd0, instr_valid}, 16'd1);
                    chk("halt_flag", {15'd0, halted}, 16'd1);
                    chk("halt_instr_pc", instr_pc, 16'h0006);
                    chk("halt_instr", instr, 16'hF000);
                end
                4: begin
                    chk("drain_req", {15'd0, imem_req}, 16'd1);
                    chk("drain_addr", imem_addr, 16'h0042);
                    chk("drain_valid", {15'd0, instr_valid}, 16'd0);
                end
                5: begin
                    chk("unhalt_flag", {15'd0, halted}, 16'd0);
                    chk("unhalt_valid", {15'd0, instr_valid}, 16'd0);
                    chk("unhalt_req", {15'd0, imem_req}, 16'd1);
                    chk("unhalt_addr", imem_addr, 16'h0040);
                end
                default: ;
            endcase
            if (to_cnt != to_seen) begin
                to_seen = to_cnt;
                total++;
                bad++;
                $display("FAIL timeout: instr_valid never shown for pc %h", to_pc);
            end
            if (end_chk && !end_done) begin
                end_done = 1'b1;
                total++;
                if (exp_addr.size() != 0 || exp_ins.size() != 0) begin
                    bad++;
                    $display("FAIL leftover: addr q %0d instr q %0d expected 0 0",
                             exp_addr.size(), exp_ins.size());
                end
            end
            prev_valid = instr_valid;
            prev_ready = instr_ready;
            prev_halted = halted;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_i(input logic [15:0] ins, input logic [15:0] pc,
                          input logic [15:0] pc2, input logic hlt);
        exp_t e;
        e.ins = ins;
        e.pc = pc;
        e.pc2 = pc2;
        e.hlt = hlt;
        exp_ins.push_back(e);
    endtask

    task automatic wait_valid_pc(input logic [15:0] pc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(instr_valid && instr_pc == pc) && n < 200);
        if (!(instr_valid && instr_pc == pc)) begin
            to_pc = pc;
            to_cnt++;
        end
    endtask

    task automatic wait_halted();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!halted && n < 200);
        if (!halted) begin
            to_pc = 16'h0006;
            to_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        instr_ready = 1'b1;
        redirect = 1'b0;
        redirect_target = 16'h0000;
        inj_ack = 1'b0;
        mem_lat = 1;
        mode = 1;
        to_cnt = 0;
        to_pc = 16'h0000;
        end_chk = 1'b0;

        // reset values, then wrap from FFFE and sequential fetch
        repeat (3) @(posedge clk);
        #1;
        exp_addr.push_back(16'hFFFE);
        exp_addr.push_back(16'h0000);
        exp_addr.push_back(16'h0002);
        push_i(16'h1FFE, 16'hFFFE, 16'h0000, 1'b0);
        push_i(16'h1000, 16'h0000, 16'h0002, 1'b0);
        push_i(16'h1002, 16'h0002, 16'h0004, 1'b0);
        mode = 0;
        rst = 1'b0;
        wait_valid_pc(16'h0002);

        // decode stalls at 0004; a stray ack during HOLD must be ignored
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        exp_addr.push_back(16'h0004);
        push_i(16'h1004, 16'h0004, 16'h0006, 1'b0);
        wait_valid_pc(16'h0004);
        @(posedge clk);
        #1;
        mode = 2;
        for (int i = 0; i < 5; i++) begin
            inj_ack = (i == 1);
            @(posedge clk);
            #1;
        end
        inj_ack = 1'b0;
        mode = 0;

        // HALT at 0006, ready ignored, then redirect to 0040
        exp_addr.push_back(16'h0006);
        push_i(16'hF000, 16'h0006, 16'h0008, 1'b1);
        instr_ready = 1'b1;
        wait_halted();
        @(posedge clk);
        #1;
        mode = 3;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        mode = 0;
        exp_addr.push_back(16'h0040);
        push_i(16'h1040, 16'h0040, 16'h0042, 1'b0);
        redirect = 1'b1;
        redirect_target = 16'h0040;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        mode = 5;
        @(posedge clk);
        #1;
        mode = 0;
        wait_valid_pc(16'h0040);

        // redirect to 0101 while 0042 waits on a 3-cycle memory
        mem_lat = 3;
        exp_addr.push_back(16'h0042);
        exp_addr.push_back(16'h0100);
        push_i(16'h1100, 16'h0100, 16'h0102, 1'b0);
        @(posedge clk);
        #1;
        redirect = 1'b1;
        redirect_target = 16'h0101;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        mode = 4;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mode = 0;
        wait_valid_pc(16'h0100);

        // reset lands in the same cycle as the ack for 0102
        mem_lat = 1;
        exp_addr.push_back(16'h0102);
        @(posedge clk);
        #1;
        rst = 1'b1;
        instr_ready = 1'b0;
        @(posedge clk);
        #1;
        mode = 1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mode = 0;
        exp_addr.push_back(16'hFFFE);
        push_i(16'h1FFE, 16'hFFFE, 16'h0000, 1'b0);
        rst = 1'b0;
        wait_valid_pc(16'hFFFE);

        @(posedge clk);
        #1;
        end_chk = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
